// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//
// Single-clock synchronous FIFO used on the ADC sample path and the 10BASE-T
// frame path. It can present the head word directly (first-word-fall-through)
// or through a registered read port. It also reports occupancy,
// almost-full/almost-empty levels and sticky overflow/underflow errors.
//
// Parameters:
//   DBITS      - data word width
//   ABITS      - address bits; depth is 2**ABITS and every entry is usable
//   FWFT       - 1: head word visible on dout while not empty
//                0: dout loads the head word on the edge that accepts a read
//   AFULL_LVL  - almost_full asserts when count >= AFULL_LVL
//   AEMPTY_LVL - almost_empty asserts when count <= AEMPTY_LVL
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high reset
//   wr, din      - write request and write data, sampled every edge
//   rd           - read request, sampled every edge
//   dout         - read data
//   empty, full  - occupancy is 0 / occupancy is 2**ABITS
//   almost_empty - count <= AEMPTY_LVL
//   almost_full  - count >= AFULL_LVL
//   count        - current occupancy, 0..2**ABITS
//   overflow     - sticky: a write was attempted while full
//   underflow    - sticky: a read was attempted while empty
//   clear_err    - clears overflow and underflow (a new error in the same
//                  cycle takes priority)
// -----------------------------------------------------------------------------
module stream_fifo #(
   parameter int DBITS      = 8,
   parameter int ABITS      = 4,
   parameter int FWFT       = 1,
   parameter int AFULL_LVL  = 12,
   parameter int AEMPTY_LVL = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr,
   input  logic [DBITS-1:0] din,
   input  logic             rd,
   output logic [DBITS-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [ABITS:0]   count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clear_err
);

   localparam int DEPTH = 2 ** ABITS;
   localparam int CW    = ABITS + 1;

   localparam logic [ABITS:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [ABITS:0] AFULL_C  = CW'(AFULL_LVL);
   localparam logic [ABITS:0] AEMPTY_C = CW'(AEMPTY_LVL);

   // The level thresholds must be ordered and must fit inside the FIFO.
   // Otherwise the flags would be meaningless, so elaboration stops.
   if (!((AEMPTY_LVL >= 0) && (AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH))) begin : g_bad_levels
      $fatal(1, "stream_fifo: need 0 <= AEMPTY_LVL < AFULL_LVL <= 2**ABITS");
   end

   logic [DBITS-1:0] mem [DEPTH];
   logic [ABITS-1:0] wr_ptr;
   logic [ABITS-1:0] rd_ptr;
   logic [ABITS:0]   count_q;
   logic             wr_acc;
   logic             rd_acc;

   // Accept decisions use only the registered state. A write to a full
   // FIFO is dropped even if a read frees a slot in the same cycle.
   assign wr_acc = wr & ~full;
   assign rd_acc = rd & ~empty;

   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign almost_full  = (count_q >= AFULL_C);

   // The storage array has no reset. Reset only rewinds the pointers,
   // which discards any stored words.
   always_ff @(posedge clock) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy. The pointers are exactly ABITS wide, so they
   // wrap on their own. The count carries one extra bit so it can
   // distinguish full from empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags. A new error has priority over clear_err, so an
   // error that occurs in the clearing cycle is not lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr && full) begin
            overflow <= 1'b1;
         end else if (clear_err) begin
            overflow <= 1'b0;
         end
         if (rd && empty) begin
            underflow <= 1'b1;
         end else if (clear_err) begin
            underflow <= 1'b0;
         end
      end
   end

   if (FWFT != 0) begin : g_fwft
      // The head word is always on the bus. When a read and a write coincide
      // at count 1, the new word lands exactly where rd_ptr moves to, so it
      // appears after the edge with no extra handling.
      assign dout = mem[rd_ptr];
   end else begin : g_registered
      logic [DBITS-1:0] dout_q;

      // Registered read port: it loads the head on an accepted read and
      // holds its value otherwise.
      always_ff @(posedge clock) begin
         if (reset) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
         end
      end

      assign dout = dout_q;
   end

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//
// Drives one stimulus stream into two stream_fifo instances: one with the
// fall-through read port (FWFT=1) and one with the registered read port
// (FWFT=0). Both instances are compared every cycle against a queue-based
// model. Directed scenarios pin the model with hand-computed values, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

   localparam int DEPTH = 16;

   logic       clock;
   logic       reset;
   logic       wr;
   logic [7:0] din;
   logic       rd;
   logic       clear_err;

   logic [7:0] f1_dout, f0_dout;
   logic       f1_empty, f0_empty, f1_full, f0_full;
   logic       f1_ae, f0_ae, f1_af, f0_af;
   logic [4:0] f1_count, f0_count;
   logic       f1_ovf, f0_ovf, f1_unf, f0_unf;

   int n_checks;
   int n_fail;

   // Model state: the stored words, the sticky flags and the registered
   // read port.
   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_unf;
   logic [7:0] m_dout0;
   bit         started;
   bit         m_full_now;
   bit         m_empty_now;
   bit         m_wa;
   bit         m_ra;
   logic [7:0] m_head;

   stream_fifo #(.DBITS(8), .ABITS(4), .FWFT(1), .AFULL_LVL(12), .AEMPTY_LVL(2)) dut_fwft (
      .clock(clock), .reset(reset), .wr(wr), .din(din), .rd(rd), .dout(f1_dout),
      .empty(f1_empty), .full(f1_full), .almost_empty(f1_ae), .almost_full(f1_af),
      .count(f1_count), .overflow(f1_ovf), .underflow(f1_unf), .clear_err(clear_err)
   );

   stream_fifo #(.DBITS(8), .ABITS(4), .FWFT(0), .AFULL_LVL(12), .AEMPTY_LVL(2)) dut_reg (
      .clock(clock), .reset(reset), .wr(wr), .din(din), .rd(rd), .dout(f0_dout),
      .empty(f0_empty), .full(f0_full), .almost_empty(f0_ae), .almost_full(f0_af),
      .count(f0_count), .overflow(f0_ovf), .underflow(f0_unf), .clear_err(clear_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change 1 time unit after a rising edge. The task then waits
   // for the edge that samples them and returns just after it.
   task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r,
                                input bit ce, input bit rs);
      wr        = w;
      din       = d;
      rd        = r;
      clear_err = ce;
      reset     = rs;
      @(posedge clock);
      #1;
   endtask

   // Reference model, written in queue terms. The accept decisions use the
   // occupancy before the edge.
   always @(posedge clock) begin
      if (reset) begin
         q.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_dout0 = 8'h00;
         started = 1'b1;
      end else begin
         m_full_now  = (q.size() == DEPTH);
         m_empty_now = (q.size() == 0);
         m_wa        = wr && !m_full_now;
         m_ra        = rd && !m_empty_now;
         m_head      = 8'h00;
         if (m_ra) m_head = q[0];
         if (m_wa) q.push_back(din);
         if (m_ra) begin
            void'(q.pop_front());
            m_dout0 = m_head;
         end
         m_ovf = (wr && m_full_now) ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
         m_unf = (rd && m_empty_now) ? 1'b1 : (clear_err ? 1'b0 : m_unf);
      end
   end

   // Compare both instances against the model on every falling edge,
   // once the first reset has defined the state.
   always @(negedge clock) begin
      if (started) begin
         checkOutput("cmp_count1", int'(f1_count), q.size());
         checkOutput("cmp_count0", int'(f0_count), q.size());
         checkOutput("cmp_empty1", int'(f1_empty), int'(q.size() == 0));
         checkOutput("cmp_empty0", int'(f0_empty), int'(q.size() == 0));
         checkOutput("cmp_full1", int'(f1_full), int'(q.size() == DEPTH));
         checkOutput("cmp_full0", int'(f0_full), int'(q.size() == DEPTH));
         checkOutput("cmp_aempty1", int'(f1_ae), int'(q.size() <= 2));
         checkOutput("cmp_aempty0", int'(f0_ae), int'(q.size() <= 2));
         checkOutput("cmp_afull1", int'(f1_af), int'(q.size() >= 12));
         checkOutput("cmp_afull0", int'(f0_af), int'(q.size() >= 12));
         checkOutput("cmp_ovf1", int'(f1_ovf), int'(m_ovf));
         checkOutput("cmp_ovf0", int'(f0_ovf), int'(m_ovf));
         checkOutput("cmp_unf1", int'(f1_unf), int'(m_unf));
         checkOutput("cmp_unf0", int'(f0_unf), int'(m_unf));
         checkOutput("cmp_dout0", int'(f0_dout), int'(m_dout0));
         if (q.size() != 0) begin
            checkOutput("cmp_dout1", int'(f1_dout), int'(q[0]));
         end
      end
   end

   // Directed scenarios with hand-computed expectations, then random traffic.
   initial begin
      int wr_pct;
      int rd_pct;
      n_checks  = 0;
      n_fail    = 0;
      started   = 1'b0;
      wr        = 1'b0;
      din       = 8'h00;
      rd        = 1'b0;
      clear_err = 1'b0;
      reset     = 1'b1;
      @(posedge clock);
      #1;

      // Reset state
      applyStimulus(0, 8'h00, 0, 0, 1);
      checkOutput("rst_count", int'(f1_count), 0);
      checkOutput("rst_empty", int'(f1_empty), 1);
      checkOutput("rst_aempty", int'(f1_ae), 1);
      checkOutput("rst_full", int'(f1_full), 0);
      checkOutput("rst_dout0", int'(f0_dout), 0);

      // Fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 8'(i), 0, 0, 0);
         checkOutput("t1_count", int'(f1_count), i + 1);
         checkOutput("t1_afull", int'(f1_af), int'(i + 1 >= 12));
         checkOutput("t1_full", int'(f1_full), int'(i == 15));
         checkOutput("t1_empty", int'(f1_empty), 0);
      end

      // Write while full with a simultaneous read: the write is dropped
      applyStimulus(1, 8'hAA, 1, 0, 0);
      checkOutput("t2_count", int'(f1_count), 15);
      checkOutput("t2_ovf", int'(f1_ovf), 1);
      checkOutput("t2_dout1", int'(f1_dout), 8'h01);
      checkOutput("t2_dout0", int'(f0_dout), 8'h00);
      for (int i = 1; i < 16; i++) begin
         checkOutput("t2_head1", int'(f1_dout), i);
         applyStimulus(0, 8'h00, 1, 0, 0);
         checkOutput("t2_read0", int'(f0_dout), i);
      end
      checkOutput("t2_empty", int'(f1_empty), 1);

      // Underflow, clear, and set-wins-over-clear
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("t3_unf", int'(f1_unf), 1);
      checkOutput("t3_count", int'(f1_count), 0);
      applyStimulus(0, 8'h00, 0, 1, 0);
      checkOutput("t3_unf_clr", int'(f1_unf), 0);
      checkOutput("t3_ovf_clr", int'(f1_ovf), 0);
      applyStimulus(0, 8'h00, 1, 1, 0);
      checkOutput("t3_unf_set_wins", int'(f1_unf), 1);
      applyStimulus(0, 8'h00, 0, 1, 0);

      // Steady streaming at count 3; both pointers wrap twice
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         checkOutput("t4_head1", int'(f1_dout), 8'h10 + i);
         applyStimulus(1, 8'(8'h13 + i), 1, 0, 0);
         checkOutput("t4_count", int'(f1_count), 3);
         checkOutput("t4_read0", int'(f0_dout), 8'h10 + i);
      end
      checkOutput("t4_head_end", int'(f1_dout), 8'h38);

      // Registered read port timing and hold
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(1, 8'h5A, 0, 0, 0);
      checkOutput("t5_fwft_head", int'(f1_dout), 8'h5A);
      checkOutput("t5_dout0_before", int'(f0_dout), 8'h00);
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("t5_dout0_read", int'(f0_dout), 8'h5A);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 8'h00, 0, 0, 0);
         checkOutput("t5_dout0_hold", int'(f0_dout), 8'h5A);
      end

      // Read and write together at count 1
      applyStimulus(1, 8'h77, 0, 0, 0);
      applyStimulus(1, 8'h78, 1, 0, 0);
      checkOutput("rw1_dout1", int'(f1_dout), 8'h78);
      checkOutput("rw1_count", int'(f1_count), 1);
      checkOutput("rw1_dout0", int'(f0_dout), 8'h77);

      // Reset mid-operation, with wr held high
      for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h20 + i), 0, 0, 0);
      checkOutput("t6_count9", int'(f1_count), 9);
      applyStimulus(1, 8'hEE, 0, 0, 1);
      checkOutput("t6_count", int'(f1_count), 0);
      checkOutput("t6_empty", int'(f1_empty), 1);
      checkOutput("t6_aempty", int'(f1_ae), 1);
      checkOutput("t6_afull", int'(f1_af), 0);
      applyStimulus(1, 8'h41, 0, 0, 0);
      checkOutput("t6_first1", int'(f1_dout), 8'h41);
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("t6_first0", int'(f0_dout), 8'h41);

      // Random traffic; the bias changes every 50 cycles so that the run
      // spends time both near full and near empty.
      wr_pct = 50;
      rd_pct = 50;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            wr_pct = int'($urandom_range(10, 90));
            rd_pct = int'($urandom_range(10, 90));
         end
         applyStimulus(($urandom_range(0, 99) < wr_pct), 8'($urandom),
                       ($urandom_range(0, 99) < rd_pct),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 127) == 0));
      end

      applyStimulus(0, 8'h00, 0, 0, 0);
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
